// File: rtl/match_tally_pkg.sv
// Shared types and limits for the match tally block.
package match_tally_pkg;
  typedef enum logic {L_IDLE, L_HOLD} led_state_t;
  localparam logic [7:0] GAP_MAX = 8'd255;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/match_tally_bcd_counter2.sv
// Two-digit BCD incrementer with wrap/saturate at 99; one-cycle update latency.
// carry_out is combinational, flagging an increment that arrives while at 99; no backpressure.
module bcd_counter2
  import match_tally_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out
);

  logic at_max;

  assign at_max    = (tens == BCD_MAX) && (ones == BCD_MAX);
  assign carry_out = inc && !clr && at_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (ones != BCD_MAX) begin
        ones <= ones + 4'd1;
      end else if (tens != BCD_MAX) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else if (WRAP) begin
        ones <= 4'd0;
        tens <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/match_tally.sv
// Counts detector match edges (BCD), stretches them into an LED pulse and measures edge spacing.
// All effects visible one cycle after match_in rises; pure consumer, no backpressure.
module match_tally
  import match_tally_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter bit WRAP        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       match_in,
  input  logic       clear,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       overflow,
  output logic       led_hold,
  output logic [7:0] last_gap,
  output logic       gap_valid
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  logic          prev;
  logic          match_edge;
  logic          take;
  logic          carry_out;
  logic [7:0]    gap_cnt;
  logic          seen_first;
  led_state_t    led_state;
  logic [HW-1:0] hold_cnt;

  assign match_edge = match_in && !prev;
  // A clear in the same cycle swallows the edge entirely.
  assign take       = match_edge && !clear;
  assign led_hold   = (led_state == L_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= match_in;
  end

  bcd_counter2 #(.WRAP(WRAP)) u_bcd (
    .clk       (clk),
    .reset     (reset),
    .clr       (clear),
    .inc       (take),
    .tens      (count_tens),
    .ones      (count_ones),
    .carry_out (carry_out)
  );

  // gap_cnt restarts at 1 on an edge, so at the next edge it already equals the spacing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      gap_cnt    <= 8'd0;
      last_gap   <= 8'd0;
      gap_valid  <= 1'b0;
      seen_first <= 1'b0;
    end else if (clear) begin
      overflow   <= 1'b0;
      gap_cnt    <= 8'd0;
      last_gap   <= 8'd0;
      gap_valid  <= 1'b0;
      seen_first <= 1'b0;
    end else begin
      if (carry_out) overflow <= 1'b1;
      if (take) begin
        gap_cnt    <= 8'd1;
        seen_first <= 1'b1;
        if (seen_first) begin
          last_gap  <= gap_cnt;
          gap_valid <= 1'b1;
        end
      end else if (gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_state <= L_IDLE;
      hold_cnt  <= '0;
    end else if (clear) begin
      led_state <= L_IDLE;
      hold_cnt  <= '0;
    end else begin
      case (led_state)
        L_IDLE: begin
          if (take) begin
            led_state <= L_HOLD;
            hold_cnt  <= HOLD_RELOAD;
          end
        end
        L_HOLD: begin
          if (take) begin
            hold_cnt <= HOLD_RELOAD;
          end else if (hold_cnt == '0) begin
            led_state <= L_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: led_state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_tally.sv
// Randomized and directed bench for match_tally, wrapping and saturating instances side by side.
module tb_match_tally;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  logic match_in;
  logic clear;

  logic [3:0] w_tens, w_ones, s_tens, s_ones;
  logic       w_ovf, s_ovf, w_led, s_led, w_gv, s_gv;
  logic [7:0] w_gap, s_gap;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  match_tally #(.HOLD_CYCLES(HOLD), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .match_in(match_in), .clear(clear),
    .count_tens(w_tens), .count_ones(w_ones), .overflow(w_ovf),
    .led_hold(w_led), .last_gap(w_gap), .gap_valid(w_gv)
  );

  match_tally #(.HOLD_CYCLES(HOLD), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .match_in(match_in), .clear(clear),
    .count_tens(s_tens), .count_ones(s_ones), .overflow(s_ovf),
    .led_hold(s_led), .last_gap(s_gap), .gap_valid(s_gv)
  );

  // Reference model: tally as an integer, edges timestamped by cycle number.
  int m_cyc, m_tw, m_ts, m_edges, m_last_edge, m_gap, m_led_end;
  bit m_ow, m_os, m_prev, m_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc = 0; m_tw = 0; m_ts = 0; m_edges = 0; m_last_edge = 0;
      m_gap = 0; m_led_end = 0; m_ow = 0; m_os = 0; m_prev = 0;
    end else begin
      m_cyc++;
      m_e    = match_in && !m_prev;
      m_prev = match_in;
      if (clear) begin
        m_tw = 0; m_ts = 0; m_ow = 0; m_os = 0;
        m_edges = 0; m_gap = 0; m_led_end = 0;
      end else if (m_e) begin
        if (m_tw == 99) begin m_ow = 1; m_tw = 0; end else m_tw++;
        if (m_ts == 99) m_os = 1; else m_ts++;
        if (m_edges > 0) m_gap = (m_cyc - m_last_edge > 255) ? 255 : m_cyc - m_last_edge;
        m_edges++;
        m_last_edge = m_cyc;
        m_led_end   = m_cyc + HOLD;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("w_tally", w_tens * 10 + w_ones, m_tw);
      chk("s_tally", s_tens * 10 + s_ones, m_ts);
      chk("w_digits_bcd", int'(w_tens <= 9 && w_ones <= 9), 1);
      chk("w_ovf", w_ovf, m_ow);
      chk("s_ovf", s_ovf, m_os);
      chk("w_led", w_led, int'(m_cyc < m_led_end));
      chk("s_led", s_led, int'(m_cyc < m_led_end));
      chk("w_gap", w_gap, m_gap);
      chk("s_gap", s_gap, m_gap);
      chk("w_gv", w_gv, int'(m_edges >= 2));
      chk("s_gv", s_gv, int'(m_edges >= 2));
    end
  end

  // Inputs change just after a negedge and are held through the following posedge.
  task automatic drive(input bit m, input bit c);
    match_in = m;
    clear    = c;
    @(negedge clk);
  endtask

  task automatic pulse();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  int led_cnt;

  initial begin
    reset = 1'b0; match_in = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tally", w_tens * 10 + w_ones, 0);
    chk("rst_led", w_led, 0);
    chk("rst_gv", w_gv, 0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Three pulses spaced 4 and 6 cycles apart.
    drive(1'b1, 1'b0);
    chk("p1_tally", w_tens * 10 + w_ones, 1);
    chk("p1_gv", w_gv, 0);
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    chk("p2_tally", w_tens * 10 + w_ones, 2);
    chk("p2_gap", w_gap, 4);
    chk("p2_gv", w_gv, 1);
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    chk("p3_tally", w_tens * 10 + w_ones, 3);
    chk("p3_gap", w_gap, 6);
    drive(1'b0, 1'b1);

    // Level held 12 cycles counts once; LED high exactly HOLD cycles.
    led_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      drive(i < 12, 1'b0);
      if (w_led) led_cnt++;
    end
    chk("hold_tally", w_tens * 10 + w_ones, 1);
    chk("hold_led_len", led_cnt, 8);

    // Retrigger 5 cycles after the first edge stretches LED to 13 cycles.
    drive(1'b0, 1'b1);
    led_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      drive(i == 0 || i == 5, 1'b0);
      if (w_led) led_cnt++;
    end
    chk("retrig_led_len", led_cnt, 13);

    // Asynchronous reset mid-run with tally 37 and LED lit.
    drive(1'b0, 1'b1);
    for (int i = 0; i < 37; i++) begin
      drive(1'b1, 1'b0);
      if (i != 36) drive(1'b0, 1'b0);
    end
    chk("pre_rst_tally", w_tens * 10 + w_ones, 37);
    chk("pre_rst_led", w_led, 1);
    match_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_tally", w_tens * 10 + w_ones, 0);
    chk("async_led", w_led, 0);
    chk("async_gap", w_gap, 0);
    chk("async_gv", w_gv, 0);
    @(negedge clk);
    reset = 1'b1;

    // 100 edges: wrap to 00 vs saturate at 99, both flag overflow.
    for (int i = 0; i < 100; i++) pulse();
    chk("wrap_tally", w_tens * 10 + w_ones, 0);
    chk("wrap_ovf", w_ovf, 1);
    chk("sat_tally", s_tens * 10 + s_ones, 99);
    chk("sat_ovf", s_ovf, 1);
    pulse();
    chk("sat_tally2", s_tens * 10 + s_ones, 99);
    for (int i = 0; i < 4; i++) pulse();
    chk("pre_clr_tally", w_tens * 10 + w_ones, 5);

    // Clear wins over a coincident edge.
    drive(1'b1, 1'b1);
    chk("clr_tally", w_tens * 10 + w_ones, 0);
    chk("clr_ovf", w_ovf, 0);
    chk("clr_gv", w_gv, 0);
    chk("clr_gap", w_gap, 0);
    chk("clr_led", w_led, 0);

    // Edges 300 cycles apart saturate the gap.
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (299) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    chk("sat_gap", w_gap, 255);
    chk("sat_gap_gv", w_gv, 1);

    // Random traffic: dense, then sparse enough to exercise gap saturation.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 999) == 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
